// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared next-PC select encodings, fetch FSM states and control-word pc_sel field mapping
package instruction_fetch_unit_pkg;
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_REG    = 2'b10,
    PC_HOLD   = 2'b11
  } pc_sel_e;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;
  localparam int CW_WIDTH     = 16;
  localparam int CW_PC_SEL_LO = 4;
  function automatic pc_sel_e cw_pc_sel(input logic [CW_WIDTH-1:0] cw);
    return pc_sel_e'(cw[CW_PC_SEL_LO +: 2]);
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory req/ack bus
// Ports: req/addr driven by the fetch unit (master); ack/rdata driven by memory (slave)
interface instruction_fetch_unit_if #(parameter int PC_WIDTH = 64);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ack;
  logic [31:0]         rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/instruction_fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection with alignment check
// Ports: pc, pc_sel, branch_offset, reg_target in; next_pc, misaligned out
module next_pc_calc
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [1:0]          pc_sel,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                misaligned
);
  // the shift discards the top two offset bits and the sum wraps modulo 2^PC_WIDTH
  always_comb begin
    next_pc    = pc_sel == PC_SEQ    ? pc + PC_WIDTH'(4) :
                 pc_sel == PC_BRANCH ? pc + (branch_offset << 2) :
                 pc_sel == PC_REG    ? reg_target : pc;
    misaligned = |next_pc[1:0];
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: LEGv8 program counter and req/ack instruction fetch front end
// Ports: clock, reset (async active-low); pc_sel/branch_offset/reg_target/step from control;
//        imem master bus; instruction/instr_valid/pc/pc_plus4/fault to control
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                pc_sel,
  input  logic [PC_WIDTH-1:0]       branch_offset,
  input  logic [PC_WIDTH-1:0]       reg_target,
  input  logic                      step,
  instruction_fetch_unit_if.master  imem,
  output logic [31:0]               instruction,
  output logic                      instr_valid,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [PC_WIDTH-1:0]       pc_plus4,
  output logic                      fault
);
  fetch_state_e        state;
  logic                req;
  logic [PC_WIDTH-1:0] next_pc;
  logic                misaligned;
  next_pc_calc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc           (pc),
    .pc_sel       (pc_sel),
    .branch_offset(branch_offset),
    .reg_target   (reg_target),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );
  assign imem.req  = req;
  assign imem.addr = pc;
  assign pc_plus4  = pc + PC_WIDTH'(4);
  // HALT keeps every register frozen; only reset leaves it
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      req         <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: if (imem.ack) begin
          instruction <= imem.rdata;
          instr_valid <= 1'b1;
          req         <= 1'b0;
          state       <= EXEC;
        end
        EXEC: if (step) begin
          instr_valid <= 1'b0;
          if (misaligned) begin
            fault <= 1'b1;
            state <= HALT;
          end else begin
            pc    <= next_pc;
            req   <= 1'b1;
            state <= FETCH;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: vector table, hand-written corner sequences and random instruction stream against an instruction-level model
module tb_instruction_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h100;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [63:0] branch_offset = '0;
  logic [63:0] reg_target = '0;
  logic        step = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fault;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  instruction_fetch_unit_if #(.PC_WIDTH(64)) imem ();
  instruction_fetch_unit #(.PC_WIDTH(64), .RESET_PC(RST_PC)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .pc_sel       (pc_sel),
    .branch_offset(branch_offset),
    .reg_target   (reg_target),
    .step         (step),
    .imem         (imem),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fault        (fault)
  );
  typedef struct {
    logic [1:0]  sel;
    logic [63:0] off;
    logic [63:0] tgt;
    int          fw;
    int          ew;
    logic [63:0] exp_pc;
    logic        exp_fault;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'hD503_201F;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // asserts reset mid-cycle, checks async reset values, optionally leaves ack high across release
  task automatic do_reset(input logic ack_pending);
    #2 rst_n = 1'b0;
    imem.ack = ack_pending;
    imem.rdata = 32'hDEAD_BEEF;
    step = 1'b0;
    #1;
    chk("rst_req", imem.req, 1'b0);
    chk("rst_addr", imem.addr, RST_PC);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 64'd4);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    tick();
    chk("rst_hold_req", imem.req, 1'b0);
    rst_n = 1'b1;
    tick();
    imem.ack = 1'b0;
    chk("boot_req", imem.req, 1'b1);
    chk("boot_addr", imem.addr, RST_PC);
    chk("boot_valid", instr_valid, 1'b0);
  endtask
  // entered #1 after the edge that raised req; step is toggled freely while fetching
  task automatic fetch(input int waits, input logic [63:0] a);
    chk("fetch_req", imem.req, 1'b1);
    chk("fetch_addr", imem.addr, a);
    chk("fetch_pc_plus4", pc_plus4, a + 64'd4);
    chk("fetch_valid", instr_valid, 1'b0);
    repeat (waits) begin
      imem.ack = 1'b0;
      step = 1'($urandom);
      tick();
      chk("wait_req", imem.req, 1'b1);
      chk("wait_addr", imem.addr, a);
      chk("wait_valid", instr_valid, 1'b0);
    end
    imem.ack = 1'b1;
    imem.rdata = mem_word(a);
    step = 1'($urandom);
    tick();
    imem.ack = 1'b0;
    imem.rdata = $urandom;
    step = 1'b0;
    chk("ack_valid", instr_valid, 1'b1);
    chk("ack_instr", instruction, mem_word(a));
    chk("ack_req", imem.req, 1'b0);
    chk("ack_pc", pc, a);
  endtask
  // holds in EXEC for waits cycles with stray acks, then retires with the given select
  task automatic retire(input int waits, input logic [1:0] sel, input logic [63:0] off,
                        input logic [63:0] tgt, input logic [63:0] cur, input logic [31:0] ins);
    repeat (waits) begin
      step = 1'b0;
      imem.ack = 1'($urandom);
      imem.rdata = $urandom;
      pc_sel = 2'($urandom);
      tick();
      chk("exec_valid", instr_valid, 1'b1);
      chk("exec_instr", instruction, ins);
      chk("exec_pc", pc, cur);
      chk("exec_req", imem.req, 1'b0);
    end
    imem.ack = 1'b0;
    step = 1'b1;
    pc_sel = sel;
    branch_offset = off;
    reg_target = tgt;
    tick();
    step = 1'b0;
    pc_sel = 2'($urandom);
    branch_offset = {$urandom, $urandom};
    reg_target = {$urandom, $urandom};
    chk("retire_valid", instr_valid, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] cur;
    logic [63:0] m_pc;
    logic [63:0] nxt;
    logic [63:0] off;
    logic [63:0] tgt;
    logic [1:0]  sel;
    int          r;
    imem.ack = 1'b0;
    imem.rdata = '0;
    tv[0]  = '{2'b00, 64'd0, 64'd0, 0, 0, 64'h104, 1'b0};
    tv[1]  = '{2'b00, 64'd0, 64'd0, 3, 0, 64'h108, 1'b0};
    tv[2]  = '{2'b00, 64'd0, 64'd0, 0, 2, 64'h10C, 1'b0};
    tv[3]  = '{2'b01, 64'd3, 64'd0, 1, 0, 64'h118, 1'b0};
    tv[4]  = '{2'b10, 64'd0, 64'h200, 0, 1, 64'h200, 1'b0};
    tv[5]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 0, 64'h1F0, 1'b0};
    tv[6]  = '{2'b11, 64'd0, 64'h3, 2, 0, 64'h1F0, 1'b0};
    tv[7]  = '{2'b01, 64'h4000_0000_0000_0001, 64'd0, 0, 0, 64'h1F4, 1'b0};
    tv[8]  = '{2'b10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tv[9]  = '{2'b00, 64'd0, 64'd0, 0, 0, 64'h0, 1'b0};
    tv[10] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tv[11] = '{2'b10, 64'd0, 64'h402, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    tick();
    do_reset(1'b0);
    cur = RST_PC;
    for (int i = 0; i < 12; i++) begin
      fetch(tv[i].fw, cur);
      retire(tv[i].ew, tv[i].sel, tv[i].off, tv[i].tgt, cur, mem_word(cur));
      chk("tv_pc", pc, tv[i].exp_pc);
      chk("tv_fault", fault, tv[i].exp_fault);
      chk("tv_req", imem.req, !tv[i].exp_fault);
      cur = tv[i].exp_pc;
    end
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      imem.ack = 1'b1;
      tick();
      chk("halt_req", imem.req, 1'b0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_fault", fault, 1'b1);
      chk("halt_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    step = 1'b0;
    imem.ack = 1'b0;
    do_reset(1'b0);
    imem.ack = 1'b0;
    tick();
    do_reset(1'b1);
    fetch(0, RST_PC);
    do_reset(1'b1);
    m_pc = RST_PC;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      sel = 2'($urandom);
      off = (r < 60) ? 64'(int'($urandom_range(0, 200)) - 100) : {$urandom, $urandom};
      tgt = {$urandom, $urandom};
      if (r >= 8) tgt[1:0] = 2'b00;
      fetch(int'($urandom_range(0, 3)), m_pc);
      retire(int'($urandom_range(0, 2)), sel, off, tgt, m_pc, mem_word(m_pc));
      nxt = sel == 2'b00 ? m_pc + 64'd4 :
            sel == 2'b01 ? m_pc + off * 64'd4 :
            sel == 2'b10 ? tgt : m_pc;
      if (nxt % 64'd4 != 64'd0) begin
        chk("rnd_fault", fault, 1'b1);
        chk("rnd_halt_pc", pc, m_pc);
        chk("rnd_halt_req", imem.req, 1'b0);
        do_reset(1'($urandom));
        m_pc = RST_PC;
      end else begin
        chk("rnd_fault", fault, 1'b0);
        chk("rnd_pc", pc, nxt);
        m_pc = nxt;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
